// File: rtl/lzss_enc_if.sv
// Valid/ready stream bundle between an LZSS encoder, its word source and its code sink.
interface lzss_enc_if #(
  parameter int pDataWidth = 8,
  parameter int pCodeWidth = 13
);
  logic                  i_valid;
  logic                  ow_ready;
  logic [pDataWidth-1:0] i_data;
  logic                  i_last;
  logic                  o_valid;
  logic                  i_ready;
  logic [pCodeWidth-1:0] o_code;
  logic                  o_last;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output ow_ready, o_valid, o_code, o_last
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  ow_ready, o_valid, o_code, o_last
  );
endinterface

// File: rtl/lzss_enc_top.sv
// Streaming LZSS encoder: greedy longest-run matching against an N-deep history
// with a parallel match vector, emitting literal/match codes on a registered stream.
module lzss_enc_top #(
  parameter int pDataWidth     = 8,
  parameter int pReferenceSize = 64,
  parameter int pCodingSize    = 5,
  parameter int pCodeWidth     = 1 + ($clog2(pCodingSize) + 1) + pDataWidth
) (
  input logic       clk,
  input logic       rst_x,
  lzss_enc_if.slave bus
);
  localparam int lpOffsetWidth = $clog2(pReferenceSize);
  localparam int lpLengthWidth = $clog2(pCodingSize) + 1;
  localparam logic [lpLengthWidth-1:0] lpMaxLen = lpLengthWidth'(pCodingSize);
  localparam logic [lpLengthWidth-1:0] lpOneLen = lpLengthWidth'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  typedef logic [pDataWidth-1:0]     word_t;
  typedef logic [pReferenceSize-1:0] mvec_t;
  typedef logic [pCodeWidth-1:0]     code_t;

  state_t                   state, state_n;
  word_t                    hist [pReferenceSize+1];
  word_t                    p_word, p_word_n;
  logic [lpLengthWidth-1:0] run_len, run_len_n;
  mvec_t                    mvec, mvec_n, eq;
  code_t                    pending_code, emit_code, code_q;
  logic                     emit, emit_last, clear_hist;
  logic                     accept, slot_free, valid_q, last_q;

  // Lowest surviving offset wins.
  function automatic logic [lpOffsetWidth-1:0] prio(input mvec_t v);
    prio = '0;
    for (int i = pReferenceSize - 1; i >= 0; i--) begin
      if (v[i]) prio = lpOffsetWidth'(i);
    end
  endfunction

  // eq[o] compares the incoming word with the word two or more positions back.
  always_comb begin
    eq = '0;
    for (int o = 0; o < pReferenceSize; o++) begin
      eq[o] = (bus.i_data == hist[o+1]);
    end
  end

  always_comb begin
    if (run_len == lpOneLen) pending_code = {1'b0, {lpLengthWidth{1'b0}}, p_word};
    else                     pending_code = {1'b1, run_len - lpOneLen, pDataWidth'(prio(mvec))};
  end

  assign slot_free    = ~valid_q | bus.i_ready;
  assign bus.ow_ready = (state != S_FLUSH) & slot_free;
  assign accept       = bus.i_valid & bus.ow_ready;

  // NOTE: every output of this block is given a default first so that no path
  // through the case statement leaves a variable unassigned and infers a latch.
  always_comb begin
    state_n    = state;
    run_len_n  = run_len;
    mvec_n     = mvec;
    p_word_n   = p_word;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_code  = pending_code;
    clear_hist = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          run_len_n = lpOneLen;
          mvec_n    = eq;
          p_word_n  = bus.i_data;
          state_n   = bus.i_last ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if ((run_len < lpMaxLen) && |(mvec & eq)) begin
            run_len_n = run_len + lpOneLen;
            mvec_n    = mvec & eq;
          end else begin
            emit      = 1'b1;
            run_len_n = lpOneLen;
            mvec_n    = eq;
            p_word_n  = bus.i_data;
          end
          if (bus.i_last) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The closing code leaves with o_last and the next stream starts from zero history.
        if (slot_free) begin
          emit       = 1'b1;
          emit_last  = 1'b1;
          clear_hist = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state   <= S_IDLE;
      run_len <= '0;
      mvec    <= '0;
      p_word  <= '0;
    end else begin
      state   <= state_n;
      run_len <= run_len_n;
      mvec    <= mvec_n;
      p_word  <= p_word_n;
    end
  end

  // NOTE: the history is reset, unlike a plain data store, because zero words
  // must match against it from the first word of every stream.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int k = 0; k <= pReferenceSize; k++) hist[k] <= '0;
    end else if (clear_hist) begin
      for (int k = 0; k <= pReferenceSize; k++) hist[k] <= '0;
    end else if (accept) begin
      hist[0] <= bus.i_data;
      for (int k = 1; k <= pReferenceSize; k++) hist[k] <= hist[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      last_q  <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      code_q  <= emit_code;
      last_q  <= emit_last;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_code  = code_q;
  assign bus.o_last  = last_q;
endmodule
